// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : muldiv_unit                                                |
// | Description : Iterative RV32M multiply/divide unit. Shift-add multiply   |
// |               and restoring divide on operand magnitudes (32 steps),     |
// |               followed by one sign-fix cycle and a one-cycle done pulse. |
// |               Optional macro MULDIV_FAST_ZERO_EN short-circuits zero     |
// |               operands straight to DONE.                                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [5:0]      alu_ctr,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [XLEN-1:0]   r_a;        // original dividend, returned by REM/REMU on divide by zero
    logic [XLEN-1:0]   r_b_mag;    // multiplicand / divisor magnitude
    logic [XLEN-1:0]   r_hi;       // product high word / partial remainder
    logic [XLEN-1:0]   r_lo;       // multiplier -> product low word / dividend -> quotient
    logic              r_sa;
    logic              r_sb;
    logic [2:0]        r_f3;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_result;

    logic [2:0]        w_f3;
    logic              w_accept;
    logic              w_sign_a;
    logic              w_sign_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_result;
    logic              w_unused_ctr;

    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic              w_b_zero;
    logic [XLEN-1:0]   w_fix_result;

    assign w_unused_ctr = ^alu_ctr[4:3];
    assign w_f3         = alu_ctr[2:0];
    assign w_accept     = start && alu_ctr[5] && (r_state == S_IDLE) && !kill;

    // MULH/MULHSU/DIV/REM treat rs1 as signed; only MULH/DIV/REM treat rs2 as signed
    assign w_sign_a = op_a[XLEN-1] && ((w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                                       (w_f3 == 3'b100) || (w_f3 == 3'b110));
    assign w_sign_b = op_b[XLEN-1] && ((w_f3 == 3'b001) || (w_f3 == 3'b100) ||
                                       (w_f3 == 3'b110));
    assign w_mag_a  = w_sign_a ? (-op_a) : op_a;
    assign w_mag_b  = w_sign_b ? (-op_b) : op_b;

`ifdef MULDIV_FAST_ZERO_EN
    // Zero operands have a trivially known result, so skip the iteration
    assign w_fast        = (op_a == '0) || (op_b == '0);
    assign w_fast_result = (w_f3[2] && (op_b == '0)) ? (w_f3[1] ? op_a : '1) : '0;
`else
    assign w_fast        = 1'b0;
    assign w_fast_result = '0;
`endif

    // One iteration step: shift-add for multiply, restoring subtract for divide
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b_mag} : '0);
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_b_mag});
    assign w_diff  = w_shift - {1'b0, r_b_mag};

    // Sign correction and output selection
    assign w_prod   = (r_sa ^ r_sb) ? (-{r_hi, r_lo}) : {r_hi, r_lo};
    assign w_quot   = (r_sa ^ r_sb) ? (-r_lo) : r_lo;
    assign w_rem    = r_sa ? (-r_hi) : r_hi;
    assign w_b_zero = (r_b_mag == '0);

    // Pick the architectural result for the latched funct3
    always_comb begin
        w_fix_result = '0;
        case (r_f3)
            3'b000:                 w_fix_result = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_result = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_result = w_b_zero ? '1 : w_quot;
            default:                w_fix_result = w_b_zero ? r_a : w_rem;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and status outputs; kill abandons any operation in flight
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (kill) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_W'(XLEN-1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                busy   = 1'b1;
                w_next = kill ? S_IDLE : S_DONE;
            end
            default: begin
                done   = !kill;
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b_mag  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_f3     <= 3'b000;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_a     <= op_a;
            r_b_mag <= w_mag_b;
            r_hi    <= '0;
            r_lo    <= w_mag_a;
            r_sa    <= w_sign_a;
            r_sb    <= w_sign_b;
            r_f3    <= w_f3;
            r_cnt   <= '0;
            if (w_fast) begin
                r_result <= w_fast_result;
            end
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (!r_f3[2]) begin
                r_hi <= w_sum[XLEN:1];
                r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
            end else begin
                r_hi <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], w_ge};
            end
        end else if ((r_state == S_FIX) && !kill) begin
            r_result <= w_fix_result;
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_muldiv_unit                                             |
// | Description : Self-checking bench for muldiv_unit against an arithmetic  |
// |               reference model of the RV32M operations.                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  alu_ctr;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_exp = 32'h0;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .alu_ctr (alu_ctr),
        .op_a    (op_a),
        .op_b    (op_b),
        .kill    (kill),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RV32M reference semantics computed with plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint     sa = longint'($signed(a));
        longint     sb = longint'($signed(b));
        longint     ub = longint'({32'h0, b});
        logic [63:0] p;
        int          si_a = $signed(a);
        int          si_b = $signed(b);
        logic        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(si_a / si_b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(si_a % si_b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation at a negedge and follow it to its done pulse
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [31:0] exp = ref_model(f3, a, b);
        int          exp_lat = 34;
        int          cyc = 0;
        int          busy_err = 0;
`ifdef MULDIV_FAST_ZERO_EN
        if (a == 0 || b == 0) exp_lat = 1;
`endif
        start   = 1'b1;
        alu_ctr = {3'b100, f3};
        op_a    = a;
        op_b    = b;
        @(negedge clk);
        cyc = 1;
        // Scramble inputs while busy: a new start must be ignored
        while (!done && cyc < 60) begin
            if (busy !== 1'b1) busy_err++;
            op_a    = $urandom;
            op_b    = $urandom;
            alu_ctr = {3'b100, 3'($urandom_range(0, 7))};
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check_eq({tag, "_busy_while_calc"}, 32'(busy_err), 32'd0);
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check_eq({tag, "_result"}, result, exp);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_result_held"}, result, exp);
        last_exp = exp;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; alu_ctr = 6'd0; op_a = 32'd0; op_b = 32'd0; kill = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, "mul");
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000, "mulh");
        run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhsu");
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhu");
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         "div");
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         "rem");
        run_op(3'd5, 32'd7,          32'd2,         "divu");
        run_op(3'd7, 32'd7,          32'd2,         "remu");
        run_op(3'd5, 32'd5,          32'd0,         "divu_by0");
        run_op(3'd6, 32'd5,          32'd0,         "rem_by0");
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, "div_ovf");
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, "rem_ovf");
        run_op(3'd0, 32'd0,          32'h1234_5678, "mul_zero");

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), "rand");
        end

        // kill in cycle 10 of a divide: back to IDLE, no done, result unchanged
        begin
            int saw_done = 0;
            start = 1'b1; alu_ctr = 6'b100100; op_a = 32'd1000; op_b = 32'd3;
            @(negedge clk);
            start = 1'b0;
            repeat (9) @(negedge clk);
            kill = 1'b1;
            @(negedge clk);
            kill = 1'b0;
            check_eq("kill_busy", 32'(busy), 32'd0);
            check_eq("kill_result", result, last_exp);
            for (int i = 0; i < 40; i++) begin
                if (done) saw_done++;
                @(negedge clk);
            end
            check_eq("kill_no_done", 32'(saw_done), 32'd0);
        end

        // start without the M-op flag is ignored
        begin
            int saw = 0;
            start = 1'b1; alu_ctr = 6'b000000; op_a = 32'd9; op_b = 32'd4;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (done || busy) saw++;
                @(negedge clk);
            end
            check_eq("ignore_non_m", 32'(saw), 32'd0);
            check_eq("ignore_result", result, last_exp);
        end

        // kill together with start in IDLE blocks the accept
        begin
            start = 1'b1; kill = 1'b1; alu_ctr = 6'b100000; op_a = 32'd3; op_b = 32'd3;
            @(negedge clk);
            start = 1'b0; kill = 1'b0;
            check_eq("kill_blocks_accept", 32'(busy || done), 32'd0);
        end

        // make the result nonzero, then reset mid-operation
        run_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0010, "pre_rst");
        start = 1'b1; alu_ctr = 6'b100100; op_a = 32'd100; op_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_result", result, 32'd0);

        run_op(3'd7, 32'd100, 32'd7, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
